// File: rtl/sevenseg_pkg.sv
// Shared constants, state encoding and frame type for the seven-segment scan controller.
package sevenseg_pkg;

  localparam int unsigned FRAME_W    = 16;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIGIT_W    = $clog2(NUM_DIGITS);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShift,
    StLatch,
    StDwell
  } state_e;

  typedef logic [NUM_DIGITS-1:0][FRAME_W-1:0] frame_t;

  // Clock cycles spent on one digit: load, shift, latch and dwell.
  function automatic int unsigned digit_period(input int unsigned clk_div,
                                               input int unsigned dwell);
    return 1 + 2 * FRAME_W * clk_div + clk_div + dwell;
  endfunction

endpackage

// File: rtl/sevenseg_shifter.sv
// Serialises one digit word MSB-first: sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
module sevenseg_shifter
  import sevenseg_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               start,
  input  logic [FRAME_W-1:0] word,
  output logic               sdo,
  output logic               sclk,
  output logic               done
);

  localparam int unsigned DivW = $clog2(2 * CLK_DIV);
  localparam int unsigned BitW = $clog2(FRAME_W);
  localparam logic [DivW-1:0] DivLast = DivW'(2 * CLK_DIV - 1);
  localparam logic [DivW-1:0] DivHigh = DivW'(CLK_DIV);
  localparam logic [BitW-1:0] BitLast = BitW'(FRAME_W - 1);

  logic [DivW-1:0]    div_q;
  logic [BitW-1:0]    bit_q;
  logic [FRAME_W-1:0] shreg_q;
  logic               period_end;

  assign period_end = start && (div_q == DivLast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
    end else if (load) begin
      div_q   <= '0;
      bit_q   <= '0;
      shreg_q <= word;
    end else if (start) begin
      if (period_end) begin
        div_q   <= '0;
        bit_q   <= bit_q + 1'b1;
        shreg_q <= {shreg_q[FRAME_W-2:0], 1'b0};
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

  // Both lines are forced low outside the shift window so the chain never sees a stray edge.
  assign sdo  = start & shreg_q[FRAME_W-1];
  assign sclk = start & (div_q >= DivHigh);
  assign done = period_end & (bit_q == BitLast);

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Scan controller: double-buffered frame handshake, per-digit shift/latch/dwell sequencing.
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned DWELL   = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          upd_valid,
  input  logic [NUM_DIGITS*FRAME_W-1:0] upd_data,
  output logic                          upd_ready,
  output logic                          sdo,
  output logic                          sclk,
  output logic                          latch,
  output logic [DIGIT_W-1:0]            digit,
  output logic                          frame_done,
  output logic                          busy
);

  localparam int unsigned TmrMax = (CLK_DIV > DWELL) ? CLK_DIV : DWELL;
  localparam int unsigned TmrW   = $clog2(TmrMax + 1);
  localparam logic [DIGIT_W-1:0] DigitLast = DIGIT_W'(NUM_DIGITS - 1);

  state_e             state_q, state_d;
  logic [TmrW-1:0]    tmr_q, tmr_d;
  logic [DIGIT_W-1:0] digit_q, digit_d;
  frame_t             active_q, pend_q;
  logic               pend_full_q, pend_full_d;
  logic               upd_ready_q;
  logic               accept, swap, shift_done;
  logic               tmr_last_latch, tmr_last_dwell;

  assign accept         = upd_valid & upd_ready_q;
  assign tmr_last_latch = (tmr_q == TmrW'(CLK_DIV - 1));
  assign tmr_last_dwell = (tmr_q == TmrW'(DWELL - 1));
  assign frame_done     = (state_q == StDwell) && tmr_last_dwell && (digit_q == DigitLast);
  // Swap only uses a frame that was already pending when the boundary cycle began.
  assign swap           = frame_done & pend_full_q;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    digit_d = digit_q;
    unique case (state_q)
      StIdle: begin
        if (enable) state_d = StLoad;
      end
      StLoad: begin
        state_d = StShift;
        tmr_d   = '0;
      end
      StShift: begin
        if (shift_done) state_d = StLatch;
      end
      StLatch: begin
        if (tmr_last_latch) begin
          state_d = StDwell;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StDwell: begin
        if (tmr_last_dwell) begin
          tmr_d   = '0;
          digit_d = (digit_q == DigitLast) ? '0 : digit_q + 1'b1;
          state_d = enable ? StLoad : StIdle;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pend_full_d = pend_full_q;
    if (swap) begin
      pend_full_d = 1'b0;
    end else if (accept) begin
      pend_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      tmr_q       <= '0;
      digit_q     <= '0;
      active_q    <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      upd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      digit_q     <= digit_d;
      pend_full_q <= pend_full_d;
      upd_ready_q <= ~pend_full_d;
      if (accept) pend_q <= upd_data;
      if (swap) active_q <= pend_q;
    end
  end

  sevenseg_shifter #(
    .CLK_DIV(CLK_DIV)
  ) u_shifter (
    .clk  (clk),
    .rst  (rst),
    .load (state_q == StLoad),
    .start(state_q == StShift),
    .word (active_q[digit_q]),
    .sdo  (sdo),
    .sclk (sclk),
    .done (shift_done)
  );

  assign upd_ready = upd_ready_q;
  assign latch     = (state_q == StLatch);
  assign busy      = (state_q != StIdle);
  assign digit     = digit_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Scoreboard bench: expected digit words queued per frame, compared against latched shift captures.
module tb_sevenseg_scan_ctrl;

  localparam int CLK_DIV = 2;
  localparam int DWELL   = 10;
  localparam int PERIOD  = 1 + 2 * 16 * CLK_DIV + CLK_DIV + DWELL;  // 77
  localparam int FRAME   = 4 * PERIOD;                              // 308

  localparam logic [63:0] F1 = 64'h8001_00FF_F00F_1234;
  localparam logic [63:0] FA = 64'hDEAD_BEEF_CAFE_0001;
  localparam logic [63:0] FB = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] FC = 64'hFFFF_5A5A_0000_C3C3;
  localparam logic [63:0] FD = 64'h1111_2222_3333_4444;

  logic        clk = 1'b0;
  logic        rst, enable, upd_valid;
  logic [63:0] upd_data;
  logic        upd_ready, sdo, sclk, latch, frame_done, busy;
  logic [1:0]  digit;

  sevenseg_scan_ctrl #(
    .CLK_DIV(CLK_DIV),
    .DWELL  (DWELL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .upd_valid (upd_valid),
    .upd_data  (upd_data),
    .upd_ready (upd_ready),
    .sdo       (sdo),
    .sclk      (sclk),
    .latch     (latch),
    .digit     (digit),
    .frame_done(frame_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          digit;
    logic [15:0] word;
    int          nbits;
    int          lat_len;
    int          cyc;
  } obs_t;

  typedef struct {
    int          digit;
    logic [15:0] word;
  } exp_t;

  obs_t obs_q[$];
  exp_t exp_q[$];
  int   fd_q[$];

  int total_cnt = 0;
  int pass_cnt  = 0;

  int          cyc = 0;
  logic        sclk_p = 1'b0, latch_p = 1'b0, busy_p = 1'b0;
  logic [15:0] cap = '0;
  int          nb = 0, llen = 0;
  int          busy_rise_cyc = 0, first_sclk_cyc = 0;
  bit          want_sclk = 1'b0;

  // Monitor: rebuilds each word from sdo at sclk rises and records it when latch falls.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        cap = '0; nb = 0; llen = 0;
        sclk_p = 1'b0; latch_p = 1'b0; busy_p = 1'b0; want_sclk = 1'b0;
      end else begin
        if (sclk && !sclk_p) begin
          cap = {cap[14:0], sdo};
          nb++;
        end
        if (latch) llen++;
        if (!latch && latch_p) begin
          obs_t o;
          o.digit = int'(digit); o.word = cap; o.nbits = nb; o.lat_len = llen; o.cyc = cyc;
          obs_q.push_back(o);
          cap = '0; nb = 0; llen = 0;
        end
        if (frame_done) fd_q.push_back(cyc);
        if (busy && !busy_p) begin
          busy_rise_cyc = cyc;
          want_sclk = 1'b1;
        end
        if (want_sclk && sclk) begin
          first_sclk_cyc = cyc;
          want_sclk = 1'b0;
        end
        sclk_p = sclk; latch_p = latch; busy_p = busy;
      end
    end
  end

  function automatic void push_frame(input logic [63:0] f);
    for (int d = 0; d < 4; d++) begin
      exp_t e;
      e.digit = d;
      e.word  = f[16*d +: 16];
      exp_q.push_back(e);
    end
  endfunction

  task automatic wait_obs(input int n, input int budget, output bit ok);
    for (int i = 0; i < budget && obs_q.size() < n; i++) @(negedge clk);
    ok = (obs_q.size() >= n);
  endtask

  task automatic wait_fd(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; upd_valid = 1'b0; upd_data = '0;
    repeat (3) @(negedge clk);
    total_cnt++; if (sdo !== 1'b0) $display("FAIL rst_sdo: got %b want 0", sdo); else pass_cnt++;
    total_cnt++; if (sclk !== 1'b0) $display("FAIL rst_sclk: got %b want 0", sclk); else pass_cnt++;
    total_cnt++; if (latch !== 1'b0) $display("FAIL rst_latch: got %b want 0", latch); else pass_cnt++;
    total_cnt++; if (digit !== 2'd0) $display("FAIL rst_digit: got %0d want 0", digit); else pass_cnt++;
    total_cnt++; if (frame_done !== 1'b0) $display("FAIL rst_fd: got %b want 0", frame_done); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (upd_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", upd_ready); else pass_cnt++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_first_frame();
    bit ok;
    int bad;
    upd_valid = 1'b1; upd_data = F1;
    @(negedge clk);
    upd_valid = 1'b0; upd_data = '0;
    total_cnt++; if (upd_ready !== 1'b0) $display("FAIL f1_accept: ready %b want 0", upd_ready); else pass_cnt++;
    obs_q.delete(); exp_q.delete(); fd_q.delete();
    push_frame(64'h0);
    push_frame(F1);
    enable = 1'b1;
    wait_obs(8, 800, ok);
    total_cnt++;
    if (!ok) begin
      $display("FAIL f1_timeout: got %0d words want 8", obs_q.size());
      return;
    end else pass_cnt++;
    for (int i = 0; i < 30 && fd_q.size() < 2; i++) @(negedge clk);
    total_cnt++;
    if (first_sclk_cyc - busy_rise_cyc !== CLK_DIV + 1)
      $display("FAIL first_sclk: got %0d want %0d", first_sclk_cyc - busy_rise_cyc, CLK_DIV + 1);
    else pass_cnt++;
    total_cnt++;
    if (obs_q[0].cyc - busy_rise_cyc !== 1 + 2 * 16 * CLK_DIV + CLK_DIV)
      $display("FAIL first_latch: got %0d want %0d", obs_q[0].cyc - busy_rise_cyc,
               1 + 2 * 16 * CLK_DIV + CLK_DIV);
    else pass_cnt++;
    bad = 0;
    for (int i = 1; i < 8; i++) if (obs_q[i].cyc - obs_q[i-1].cyc != PERIOD) bad++;
    total_cnt++; if (bad != 0) $display("FAIL digit_period: got %0d bad gaps want 0", bad); else pass_cnt++;
    total_cnt++;
    if (fd_q.size() < 2) $display("FAIL fd_count: got %0d want 2", fd_q.size());
    else if (fd_q[1] - fd_q[0] !== FRAME)
      $display("FAIL frame_period: got %0d want %0d", fd_q[1] - fd_q[0], FRAME);
    else pass_cnt++;
    total_cnt++;
    if (fd_q.size() < 1 || fd_q[0] !== obs_q[3].cyc + DWELL - 1)
      $display("FAIL fd_pos: got %0d want %0d", (fd_q.size() > 0) ? fd_q[0] : -1,
               obs_q[3].cyc + DWELL - 1);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      obs_t o;
      exp_t e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      total_cnt++;
      if (o.digit !== e.digit || o.word !== e.word || o.nbits !== 16 || o.lat_len !== CLK_DIV)
        $display("FAIL f1_word[%0d]: got d%0d %h bits %0d latch %0d want d%0d %h bits 16 latch %0d",
                 i, o.digit, o.word, o.nbits, o.lat_len, e.digit, e.word, CLK_DIV);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int k_fd, k_b;
    wait_fd(400, ok);
    total_cnt++; if (!ok) $display("FAIL b2b_sync: got no frame_done want one"); else pass_cnt++;
    obs_q.delete(); exp_q.delete();
    push_frame(F1);
    push_frame(FA);
    push_frame(FB);
    @(negedge clk);
    upd_valid = 1'b1; upd_data = FA;
    @(negedge clk);
    total_cnt++; if (upd_ready !== 1'b0) $display("FAIL a_accept: ready %b want 0", upd_ready); else pass_cnt++;
    upd_data = FB;
    k_fd = -1; k_b = -1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) k_fd = i;
      if (upd_ready === 1'b1) begin
        k_b = i;
        break;
      end
    end
    @(posedge clk);
    #1 upd_valid = 1'b0; upd_data = 64'hFFFF_0000_FFFF_0000;
    total_cnt++;
    if (k_fd < 1 || k_b !== k_fd + 1)
      $display("FAIL b_after_swap: got ready at %0d fd at %0d want ready at fd+1", k_b, k_fd);
    else pass_cnt++;
    wait_obs(12, 1300, ok);
    total_cnt++;
    if (!ok) begin
      $display("FAIL b2b_timeout: got %0d words want 12", obs_q.size());
      return;
    end else pass_cnt++;
    for (int i = 0; i < 12; i++) begin
      obs_t o;
      exp_t e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      total_cnt++;
      if (o.digit !== e.digit || o.word !== e.word || o.nbits !== 16)
        $display("FAIL b2b_word[%0d]: got d%0d %h bits %0d want d%0d %h bits 16",
                 i, o.digit, o.word, o.nbits, e.digit, e.word);
      else pass_cnt++;
    end
  endtask

  task automatic test_swap_cycle_accept();
    bit ok;
    wait_fd(400, ok);
    total_cnt++; if (!ok) $display("FAIL sc_sync: got no frame_done want one"); else pass_cnt++;
    total_cnt++; if (upd_ready !== 1'b1) $display("FAIL sc_ready: got %b want 1", upd_ready); else pass_cnt++;
    upd_valid = 1'b1; upd_data = FC;
    obs_q.delete(); exp_q.delete();
    push_frame(FB);
    push_frame(FC);
    @(posedge clk);
    #1 upd_valid = 1'b0; upd_data = 64'h0F0F_0F0F_0F0F_0F0F;
    @(negedge clk);
    total_cnt++; if (upd_ready !== 1'b0) $display("FAIL sc_pending: ready %b want 0", upd_ready); else pass_cnt++;
    wait_obs(8, 900, ok);
    total_cnt++;
    if (!ok) begin
      $display("FAIL sc_timeout: got %0d words want 8", obs_q.size());
      return;
    end else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      obs_t o;
      exp_t e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      total_cnt++;
      if (o.digit !== e.digit || o.word !== e.word)
        $display("FAIL sc_word[%0d]: got d%0d %h want d%0d %h", i, o.digit, o.word, e.digit, e.word);
      else pass_cnt++;
    end
  endtask

  task automatic test_enable_drop();
    bit ok, hit;
    wait_fd(400, ok);
    total_cnt++; if (!ok) $display("FAIL ed_sync: got no frame_done want one"); else pass_cnt++;
    obs_q.delete(); exp_q.delete();
    push_frame(FC);
    void'(exp_q.pop_back());
    hit = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (digit === 2'd2 && nb >= 5 && nb < 16) begin
        hit = 1'b1;
        break;
      end
    end
    enable = 1'b0;
    total_cnt++; if (!hit) $display("FAIL ed_reach: got no digit-2 shift want one"); else pass_cnt++;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    total_cnt++; if (!ok) $display("FAIL ed_idle: busy %b want 0", busy); else pass_cnt++;
    total_cnt++; if (digit !== 2'd3) $display("FAIL ed_digit: got %0d want 3", digit); else pass_cnt++;
    total_cnt++;
    if (obs_q.size() !== 3) begin
      $display("FAIL ed_count: got %0d words want 3", obs_q.size());
      return;
    end else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      obs_t o;
      exp_t e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      total_cnt++;
      if (o.digit !== e.digit || o.word !== e.word || o.nbits !== 16 || o.lat_len !== CLK_DIV)
        $display("FAIL ed_word[%0d]: got d%0d %h bits %0d latch %0d want d%0d %h bits 16 latch %0d",
                 i, o.digit, o.word, o.nbits, o.lat_len, e.digit, e.word, CLK_DIV);
      else pass_cnt++;
    end
    repeat (40) @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || obs_q.size() !== 0)
      $display("FAIL ed_stay: got busy %b words %0d want busy 0 words 0", busy, obs_q.size());
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    bit ok;
    @(negedge clk);
    upd_valid = 1'b1; upd_data = FD;
    @(negedge clk);
    upd_valid = 1'b0;
    total_cnt++; if (upd_ready !== 1'b0) $display("FAIL ar_pend: ready %b want 0", upd_ready); else pass_cnt++;
    enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sclk === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    total_cnt++; if (!ok || sdo !== 1'b1) $display("FAIL ar_shift: sclk %b sdo %b want 1 1", sclk, sdo); else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if (sdo !== 1'b0 || sclk !== 1'b0 || latch !== 1'b0)
      $display("FAIL ar_lines: got sdo %b sclk %b latch %b want 0 0 0", sdo, sclk, latch);
    else pass_cnt++;
    total_cnt++; if (digit !== 2'd0) $display("FAIL ar_digit: got %0d want 0", digit); else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0 || upd_ready !== 1'b1)
      $display("FAIL ar_status: got busy %b ready %b want 0 1", busy, upd_ready);
    else pass_cnt++;
    @(negedge clk);
    #1 rst = 1'b0;
    obs_q.delete(); exp_q.delete();
    push_frame(64'h0);
    push_frame(64'h0);
    wait_obs(8, 800, ok);
    total_cnt++;
    if (!ok) begin
      $display("FAIL ar_timeout: got %0d words want 8", obs_q.size());
      return;
    end else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      obs_t o;
      exp_t e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      total_cnt++;
      if (o.digit !== e.digit || o.word !== e.word || o.nbits !== 16)
        $display("FAIL ar_word[%0d]: got d%0d %h bits %0d want d%0d %h bits 16",
                 i, o.digit, o.word, o.nbits, e.digit, e.word);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_back_to_back();
    test_swap_cycle_accept();
    test_enable_drop();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion want finish before 1000000");
    $fatal(1);
  end

endmodule
